regfile_sequencer: RTL and testbench
====================================

# regfile_sequencer

Command-driven initiator for the RegisterFile write and read ports. It accepts one register-to-register command at a time and reads both source registers in one cycle. It then computes a result and writes it back to the destination register. It sits between a command source (test controller or microcode front end) and RegisterFile, and drives every RegisterFile input except clk/rst.

## Interface
Parameters:
- DATA_WIDTH, 32, width of register data and of the result path.

Ports:
- clk  input  1  rising-edge clock shared with RegisterFile.
- rst  input  1  reset; synchronous, active-high.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  3  operation code, see Operation.
- cmd_rd  input  5  destination register address.
- cmd_rs1  input  5  source register 1 address.
- cmd_rs2  input  5  source register 2 address.
- reg_we  output  5  RegisterFile write enable; 5'b10000 = write strobe, 5'b00000 = idle; bits 3:0 always 0.
- reg_waddr  output  5  RegisterFile write address.
- reg_wdata  output  DATA_WIDTH  RegisterFile write data.
- reg_raddr1  output  5  RegisterFile read address 1.
- reg_raddr2  output  5  RegisterFile read address 2.
- reg_rdata1  input  DATA_WIDTH  RegisterFile read data 1; combinational from reg_raddr1.
- reg_rdata2  input  DATA_WIDTH  RegisterFile read data 2; combinational from reg_raddr2.
- done_valid  output  1  one-cycle pulse when the command completes.
- done_data  output  DATA_WIDTH  result of the completed command; valid with done_valid.
- done_ovf  output  1  signed overflow of ADD/SUB; valid with done_valid.

## Operation
- Opcodes:
  - 000 MOV: rs1.
  - 001 ADD: rs1+rs2.
  - 010 SUB: rs1-rs2.
  - 011 AND.
  - 100 OR.
  - 101 XOR.
  - 110 SLL: rs1 << rs2[4:0].
  - 111 RD: no write; done_data = rs1.
- FSM states and transitions:
  - IDLE: cmd_ready=1. On cmd_valid, latch op/rd/rs1/rs2 and go to READ.
  - READ: drive reg_raddr1/2 from the latched rs1/rs2. Capture reg_rdata1/2 into operand registers at the edge. Go to EXEC.
  - EXEC: ALU computes from the operand registers. Register the result and ovf at the edge. Go to WRITE.
  - WRITE: drive reg_we=5'b10000, reg_waddr=rd, reg_wdata=result, and pulse done_valid. Go to IDLE.
- Write suppression: if rd==0 or op==RD, reg_we stays 5'b00000 in WRITE. done_valid still pulses.
- Arithmetic: operands are two's complement, DATA_WIDTH bits. ADD/SUB wrap modulo 2^DATA_WIDTH unless REGSEQ_SAT_EN is defined.
- done_ovf = signed overflow of the true result, for ADD/SUB only; 0 for all other ops.
- Outputs held between commands:
  - reg_waddr/reg_wdata/reg_raddr1/2 hold their last values outside their active state.
  - reg_we is 0 outside WRITE.
  - done_data holds the last result.
- Reset: all outputs 0, state IDLE, operand/result registers 0. cmd_ready is 0 while rst=1 and 1 in the first cycle after release.
- Reset mid-command: the command is abandoned.
  - rst sampled in WRITE forces reg_we=0 that cycle: the reset term dominates the write strobe combinationally.
  - No done_valid is produced.
- cmd_valid while busy is ignored. cmd_ready=0 outside IDLE, so no command is lost under the valid/ready rule.

## Timing
- Command accepted at edge N (IDLE, cmd_valid=1).
- READ occupies cycle N..N+1, EXEC N+1..N+2, WRITE N+2..N+3.
- reg_we and done_valid are high for exactly one cycle, after edge N+2. RegisterFile commits at edge N+3.
- cmd_ready returns high after edge N+3, so back-to-back throughput is one command per 4 cycles.
- Read-after-write: a following command reads no earlier than edge N+4, so it sees the prior write without forwarding.
- Simultaneous rst and cmd_valid: reset wins and the command is not accepted.

## Configuration
- REGSEQ_SAT_EN defined: ADD/SUB clamp to the signed range on overflow (0x7FFFFFFF / 0x80000000 at 32 bits), and done_ovf is still reported.
- REGSEQ_SAT_EN undefined: ADD/SUB wrap and done_ovf is reported.
- All other ops are unaffected either way.

## Structure
- Package regseq_pkg:
  - op enum (OP_MOV..OP_RD).
  - FSM state enum (S_IDLE, S_READ, S_EXEC, S_WRITE).
  - WE_STROBE = 5'b10000.
  - REG_ZERO = 5'd0.
- Sub-module regseq_alu: combinational, op + two operands in, result + ovf out. It contains the REGSEQ_SAT_EN conditional.
- Top: FSM, command latch, operand/result registers, port drive.

## Test plan
- Bench setup: a behavioural RegisterFile model is preloaded with r5=0x00000003 and r6=0x12345678.
- Directed scenarios:
  - Reset release: all outputs 0 during rst; cmd_ready=1 on the first cycle after release.
  - ADD rd=10, rs1=5, rs2=6: reg_we=5'b10000, waddr=10, wdata=0x1234567B exactly 3 cycles after accept; a following RD rs1=10 returns done_data=0x1234567B.
  - ADD of r7=0x7FFFFFFF and r8=0x00000001: result 0x80000000 with done_ovf=1 without REGSEQ_SAT_EN, 0x7FFFFFFF with done_ovf=1 with it.
  - MOV rd=0, rs1=6: reg_we stays 0, done_valid pulses, done_data=0x12345678.
  - rst asserted in WRITE: reg_we=0 that cycle, no done_valid, r10 unchanged, state IDLE.
  - cmd_valid held high across two commands: the second is accepted 4 cycles after the first and both results are written in order.

Source files
------------

// File: rtl/regseq_pkg.sv
// Shared types and constants for regfile_sequencer.
// Optional build macro: REGSEQ_SAT_EN (saturating ADD/SUB inside regseq_alu).
package regseq_pkg;

  typedef enum logic [2:0] {
    OP_MOV = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_SLL = 3'd6,
    OP_RD  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  localparam logic [4:0] WE_STROBE = 5'b10000;
  localparam logic [4:0] WE_IDLE   = 5'b00000;
  localparam logic [4:0] REG_ZERO  = 5'd0;

  // Command as captured when it is accepted.
  typedef struct packed {
    op_e        op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } cmd_t;

  // Two's complement overflow from operand/result sign bits.
  // For subtraction the second operand's sign is flipped (a - b == a + -b).
  function automatic logic signed_ovf(input logic sign_a, input logic sign_b,
                                      input logic sign_r, input logic is_sub);
    logic sign_b_eff;
    sign_b_eff = sign_b ^ is_sub;
    return (sign_a == sign_b_eff) && (sign_r != sign_a);
  endfunction

  // Commands that complete without touching the register file.
  function automatic logic write_suppressed(input cmd_t c);
    return (c.rd == REG_ZERO) || (c.op == OP_RD);
  endfunction

endpackage

// File: rtl/regseq_alu.sv
// Combinational ALU for regfile_sequencer.
// Optional build macro: REGSEQ_SAT_EN -- ADD/SUB clamp to the signed range
// on overflow instead of wrapping; overflow is flagged in both builds.
module regseq_alu
  import regseq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  op_e                   op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  ovf
);

  localparam int MSB = DATA_WIDTH - 1;

  logic [DATA_WIDTH-1:0] sum_s;
  logic [DATA_WIDTH-1:0] diff_s;
  logic [DATA_WIDTH-1:0] sum_fix_s;
  logic [DATA_WIDTH-1:0] diff_fix_s;
  logic                  sum_ovf_s;
  logic                  diff_ovf_s;

  // Wrapping add/sub and their signed overflow flags.
  always_comb begin
    sum_s      = a + b;
    diff_s     = a - b;
    sum_ovf_s  = signed_ovf(a[MSB], b[MSB], sum_s[MSB], 1'b0);
    diff_ovf_s = signed_ovf(a[MSB], b[MSB], diff_s[MSB], 1'b1);
  end

`ifdef REGSEQ_SAT_EN
  localparam logic [DATA_WIDTH-1:0] SIGNED_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SIGNED_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Clamp on overflow; an overflowed true result always has the sign of a.
  always_comb begin
    if (sum_ovf_s) begin
      sum_fix_s = a[MSB] ? SIGNED_MIN : SIGNED_MAX;
    end else begin
      sum_fix_s = sum_s;
    end
    if (diff_ovf_s) begin
      diff_fix_s = a[MSB] ? SIGNED_MIN : SIGNED_MAX;
    end else begin
      diff_fix_s = diff_s;
    end
  end
`else
  // Wrapping build: results pass straight through.
  always_comb begin
    sum_fix_s  = sum_s;
    diff_fix_s = diff_s;
  end
`endif

  // Operation select; overflow is meaningful for ADD/SUB only.
  always_comb begin
    result = a;
    ovf    = 1'b0;
    case (op)
      OP_MOV: result = a;
      OP_ADD: begin
        result = sum_fix_s;
        ovf    = sum_ovf_s;
      end
      OP_SUB: begin
        result = diff_fix_s;
        ovf    = diff_ovf_s;
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SLL: result = a << b[4:0];
      OP_RD:  result = a;
      default: begin
        result = a;
        ovf    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/regseq_checker.sv
// Protocol assertions for regfile_sequencer outputs (simulation only).
module regseq_checker
  import regseq_pkg::*;
(
  input logic       clk,
  input logic       rst,
  input logic       cmd_ready,
  input logic       done_valid,
  input logic [4:0] reg_we
);

  a_we_encoding: assert property (@(posedge clk) disable iff (rst)
    (reg_we == WE_IDLE) || (reg_we == WE_STROBE));

  a_done_single_pulse: assert property (@(posedge clk) disable iff (rst)
    done_valid |=> !done_valid);

  a_write_with_done: assert property (@(posedge clk) disable iff (rst)
    (reg_we == WE_STROBE) |-> done_valid);

  a_ready_not_done: assert property (@(posedge clk) disable iff (rst)
    !(cmd_ready && done_valid));

endmodule

// File: rtl/regfile_sequencer.sv
// Command-driven RegisterFile initiator: IDLE -> READ -> EXEC -> WRITE.
// One command in flight; reads both sources in READ, computes in EXEC,
// writes back and reports completion in WRITE.
// Optional build macro: REGSEQ_SAT_EN (saturating ADD/SUB, see regseq_alu).
module regfile_sequencer
  import regseq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [4:0]            cmd_rd,
  input  logic [4:0]            cmd_rs1,
  input  logic [4:0]            cmd_rs2,
  output logic [4:0]            reg_we,
  output logic [4:0]            reg_waddr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic [4:0]            reg_raddr1,
  output logic [4:0]            reg_raddr2,
  input  logic [DATA_WIDTH-1:0] reg_rdata1,
  input  logic [DATA_WIDTH-1:0] reg_rdata2,
  output logic                  done_valid,
  output logic [DATA_WIDTH-1:0] done_data,
  output logic                  done_ovf
);

  state_e                state_r;
  state_e                state_s;
  cmd_t                  cmd_r;
  logic                  accept_s;
  logic [DATA_WIDTH-1:0] opa_r;
  logic [DATA_WIDTH-1:0] opb_r;
  logic [DATA_WIDTH-1:0] result_r;
  logic                  ovf_r;
  logic [4:0]            waddr_r;
  logic [DATA_WIDTH-1:0] alu_result_s;
  logic                  alu_ovf_s;

  // Handshake: a command is taken only in IDLE and never while reset is high.
  always_comb begin
    if ((state_r == S_IDLE) && cmd_valid && !rst) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: fixed four-cycle walk once a command is accepted.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_s = S_READ;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_READ:  state_s = S_EXEC;
      S_EXEC:  state_s = S_WRITE;
      S_WRITE: state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // FSM outputs; reset overrides ready, strobe and done in the same cycle.
  always_comb begin
    cmd_ready  = 1'b0;
    reg_we     = WE_IDLE;
    done_valid = 1'b0;
    case (state_r)
      S_IDLE: cmd_ready = !rst;
      S_WRITE: begin
        done_valid = !rst;
        if (!rst && !write_suppressed(cmd_r)) begin
          reg_we = WE_STROBE;
        end else begin
          reg_we = WE_IDLE;
        end
      end
      default: begin
        cmd_ready  = 1'b0;
        reg_we     = WE_IDLE;
        done_valid = 1'b0;
      end
    endcase
  end

  // Command latch; it also drives the read addresses, which therefore hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_r <= '0;
    end else if (accept_s) begin
      cmd_r.op  <= op_e'(cmd_op);
      cmd_r.rd  <= cmd_rd;
      cmd_r.rs1 <= cmd_rs1;
      cmd_r.rs2 <= cmd_rs2;
    end else begin
      cmd_r <= cmd_r;
    end
  end

  // Operand capture at the end of READ.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa_r <= '0;
      opb_r <= '0;
    end else if (state_r == S_READ) begin
      opa_r <= reg_rdata1;
      opb_r <= reg_rdata2;
    end else begin
      opa_r <= opa_r;
      opb_r <= opb_r;
    end
  end

  regseq_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .op    (cmd_r.op),
    .a     (opa_r),
    .b     (opb_r),
    .result(alu_result_s),
    .ovf   (alu_ovf_s)
  );

  // Result, overflow and write address registered at the end of EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r <= '0;
      ovf_r    <= 1'b0;
      waddr_r  <= REG_ZERO;
    end else if (state_r == S_EXEC) begin
      result_r <= alu_result_s;
      ovf_r    <= alu_ovf_s;
      waddr_r  <= cmd_r.rd;
    end else begin
      result_r <= result_r;
      ovf_r    <= ovf_r;
      waddr_r  <= waddr_r;
    end
  end

  assign reg_raddr1 = cmd_r.rs1;
  assign reg_raddr2 = cmd_r.rs2;
  assign reg_waddr  = waddr_r;
  assign reg_wdata  = result_r;
  assign done_data  = result_r;
  assign done_ovf   = ovf_r;

  regseq_checker u_checker (
    .clk       (clk),
    .rst       (rst),
    .cmd_ready (cmd_ready),
    .done_valid(done_valid),
    .reg_we    (reg_we)
  );

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench for regfile_sequencer: behavioural RegisterFile plus a
// transaction-level model of each command's result, checked every cycle.
module tb_regfile_sequencer;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic [2:0]    cmd_op;
  logic [4:0]    cmd_rd, cmd_rs1, cmd_rs2;
  logic          cmd_ready;
  logic [4:0]    reg_we, reg_waddr, reg_raddr1, reg_raddr2;
  logic [DW-1:0] reg_wdata, reg_rdata1, reg_rdata2, done_data;
  logic          done_valid, done_ovf;

  logic [DW-1:0] rf  [0:31];   // environment RegisterFile, written by the DUT
  logic [DW-1:0] mrf [0:31];   // expected register contents

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model state: k = cycles since accept (0 idle, 1 read, 2 exec, 3 write)
  int            k = 0;
  logic [4:0]    m_rd, m_rs1, m_rs2;
  logic [DW-1:0] m_res;
  logic [DW-1:0] m_hold = '0;
  logic          m_ovf, m_wr;
  logic          seen_rst = 1'b0;
  int            last_acc = -1;
  int            acc_cnt = 0;

  always #5 clk = ~clk;

  assign reg_rdata1 = rf[reg_raddr1];
  assign reg_rdata2 = rf[reg_raddr2];

  regfile_sequencer #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .reg_raddr1(reg_raddr1), .reg_raddr2(reg_raddr2),
    .reg_rdata1(reg_rdata1), .reg_rdata2(reg_rdata2),
    .done_valid(done_valid), .done_data(done_data), .done_ovf(done_ovf)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int i);
    case (i)
      0:       return 32'h0000_0000;
      5:       return 32'h0000_0003;
      6:       return 32'h1234_5678;
      7:       return 32'h7FFF_FFFF;
      8:       return 32'h0000_0001;
      default: return (i * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  // Reference semantics from the opcode table, using true integer arithmetic.
  task automatic model_alu(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           output logic [DW-1:0] res, output logic ovf);
    longint sa, sb, t;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = 1'b0;
    res = a;
    case (op)
      3'd1, 3'd2: begin
        t   = (op == 3'd1) ? sa + sb : sa - sb;
        ovf = (t > 64'sh7FFF_FFFF) || (t < -64'sh8000_0000);
`ifdef REGSEQ_SAT_EN
        if (t > 64'sh7FFF_FFFF)       res = 32'h7FFF_FFFF;
        else if (t < -64'sh8000_0000) res = 32'h8000_0000;
        else                          res = t[31:0];
`else
        res = t[31:0];
`endif
      end
      3'd3:    res = a & b;
      3'd4:    res = a | b;
      3'd5:    res = a ^ b;
      3'd6:    res = a << b[4:0];
      default: res = a;
    endcase
  endtask

  // RegisterFile commit and model advance on each rising edge.
  always @(posedge clk) begin
    cyc++;
    if (reg_we == 5'b10000) rf[reg_waddr] <= reg_wdata;
    if (cyc == 1) begin
      for (int i = 0; i < 32; i++) begin
        rf[i]  <= init_val(i);
        mrf[i]  = init_val(i);
      end
    end
    if (rst) begin
      k        = 0;
      m_hold   = '0;
      seen_rst = 1'b1;
    end else begin
      seen_rst = 1'b0;
      if (k == 3) begin
        if (m_wr) mrf[m_rd] = m_res;
        k = 0;
      end else if (k > 0) begin
        k++;
        if (k == 3) m_hold = m_res;
      end else if (cmd_valid) begin
        m_rd  = cmd_rd;
        m_rs1 = cmd_rs1;
        m_rs2 = cmd_rs2;
        model_alu(cmd_op, mrf[cmd_rs1], mrf[cmd_rs2], m_res, m_ovf);
        m_wr     = (cmd_rd != 5'd0) && (cmd_op != 3'd7);
        k        = 1;
        last_acc = cyc;
        acc_cnt++;
      end
    end
  end

  // Compare DUT outputs against the model mid-cycle.
  always @(negedge clk) begin
    if (rst && seen_rst) begin
      chk("rst_ready", cmd_ready, 0);
      chk("rst_we", reg_we, 0);
      chk("rst_done", done_valid, 0);
      chk("rst_waddr", reg_waddr, 0);
      chk("rst_wdata", reg_wdata, 0);
      chk("rst_raddr1", reg_raddr1, 0);
      chk("rst_raddr2", reg_raddr2, 0);
      chk("rst_ddata", done_data, 0);
      chk("rst_ovf", done_ovf, 0);
    end else if (rst) begin
      chk("rst_edge_ready", cmd_ready, 0);
      chk("rst_edge_we", reg_we, 0);
      chk("rst_edge_done", done_valid, 0);
    end else begin
      chk("cmd_ready", cmd_ready, (k == 0));
      chk("reg_we", reg_we, (k == 3 && m_wr) ? 5'b10000 : 5'b00000);
      chk("done_valid", done_valid, (k == 3));
      chk("done_data", done_data, m_hold);
      if (k == 3) chk("done_ovf", done_ovf, m_ovf);
      if (k == 3 && m_wr) begin
        chk("reg_waddr", reg_waddr, m_rd);
        chk("reg_wdata", reg_wdata, m_res);
      end
      if (k == 1) begin
        chk("reg_raddr1", reg_raddr1, m_rs1);
        chk("reg_raddr2", reg_raddr2, m_rs2);
      end
    end
  end

  task automatic wait_accept(output int acc);
    int start;
    start = acc_cnt;
    for (int i = 0; i < 20 && acc_cnt == start; i++) begin
      @(posedge clk);
      #1;
    end
    chk("accept_timeout", (acc_cnt != start), 1);
    acc = last_acc;
  endtask

  task automatic issue(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, output int acc);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rs1   = rs1;
    cmd_rs2   = rs2;
    wait_accept(acc);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int a1, a2;
    logic [DW-1:0] pr;
    logic po;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0;
    cmd_rd = 5'd0; cmd_rs1 = 5'd0; cmd_rs2 = 5'd0;

    // pin the reference model itself
    model_alu(3'd2, 32'd3, 32'd5, pr, po);
    chk("model_sub", {pr, 31'd0, po}, {32'hFFFF_FFFE, 31'd0, 1'b0});
    model_alu(3'd6, 32'h0000_0003, 32'h0000_0024, pr, po);
    chk("model_sll", pr, 32'h0000_0030);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk) chk("ready_after_release", cmd_ready, 1);

    // ADD r10 = r5 + r6, strobe exactly three cycles after accept
    issue(3'd1, 5'd10, 5'd5, 5'd6, a1);
    @(negedge clk) chk("add_we_c1", reg_we, 0);
    @(negedge clk) chk("add_we_c2", reg_we, 0);
    @(negedge clk);
    chk("add_we", reg_we, 5'b10000);
    chk("add_waddr", reg_waddr, 5'd10);
    chk("add_wdata", reg_wdata, 32'h1234_567B);
    chk("add_done", done_valid, 1);
    @(posedge clk); #1;
    chk("add_rf10", rf[10], 32'h1234_567B);

    // RD r10
    issue(3'd7, 5'd0, 5'd10, 5'd0, a1);
    repeat (3) @(negedge clk);
    chk("rd_done", done_valid, 1);
    chk("rd_data", done_data, 32'h1234_567B);
    chk("rd_we", reg_we, 0);

    // signed overflow on ADD
    issue(3'd1, 5'd11, 5'd7, 5'd8, a1);
    repeat (3) @(negedge clk);
`ifdef REGSEQ_SAT_EN
    chk("ovf_data", done_data, 32'h7FFF_FFFF);
`else
    chk("ovf_data", done_data, 32'h8000_0000);
`endif
    chk("ovf_flag", done_ovf, 1);

    // MOV to r0 is suppressed but still completes
    issue(3'd0, 5'd0, 5'd6, 5'd0, a1);
    repeat (3) @(negedge clk);
    chk("mov0_we", reg_we, 0);
    chk("mov0_done", done_valid, 1);
    chk("mov0_data", done_data, 32'h1234_5678);

    // reset while in WRITE abandons the command
    issue(3'd1, 5'd10, 5'd5, 5'd5, a1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rstw_we", reg_we, 0);
    chk("rstw_done", done_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rstw_rf10", rf[10], 32'h1234_567B);
    @(negedge clk) chk("rstw_idle", cmd_ready, 1);

    // cmd_valid held high across two dependent commands
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_rd = 5'd12; cmd_rs1 = 5'd5; cmd_rs2 = 5'd5;
    wait_accept(a1);
    cmd_op = 3'd2; cmd_rd = 5'd13; cmd_rs1 = 5'd12; cmd_rs2 = 5'd5;
    wait_accept(a2);
    cmd_valid = 1'b0;
    chk("b2b_spacing", a2 - a1, 4);
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_r12", rf[12], 32'h0000_0006);
    chk("b2b_r13", rf[13], 32'h0000_0003);

    // randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      @(posedge clk);
      #1;
      rst       = ($urandom_range(0, 149) == 0);
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_op    = 3'($urandom_range(0, 7));
      cmd_rd    = 5'($urandom_range(0, 15));
      cmd_rs1   = 5'($urandom_range(0, 15));
      cmd_rs2   = 5'($urandom_range(0, 15));
    end
    rst = 1'b0;
    cmd_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) chk("final_rf", rf[i], mrf[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
